wb_stage_mux: RTL and testbench

WB_STAGE_MUX -- requirements
Module: wb_stage_mux

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_load_ext.sv | 32 +++
 rtl/wb_stage_mux.sv | 86 ++++++++
 tb/tb_wb_stage_mux.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback constants: source indices into the flattened source bus
// and the load-extension mode encodings.
package wb_pkg;

    localparam int SRC_ALU  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_PC4  = 2;

    localparam logic [2:0] EXT_LB  = 3'b000;
    localparam logic [2:0] EXT_LH  = 3'b001;
    localparam logic [2:0] EXT_LW  = 3'b010;
    localparam logic [2:0] EXT_LBU = 3'b100;
    localparam logic [2:0] EXT_LHU = 3'b101;

endpackage

// File: rtl/wb_load_ext.sv
// Load lane select and sign/zero extension; purely combinational, zero latency.
// Unlisted modes pass the word unchanged (same as LW).
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        ext_mode,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Halfword lane uses addr_lo[1] only; misaligned halves are not supported.
    assign byte_lane = data[{addr_lo, 3'b000} +: 8];
    assign half_lane = addr_lo[1] ? data[31:16] : data[15:0];

    always_comb begin
        result = data;
        case (ext_mode)
            EXT_LB:  result = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
            EXT_LBU: result = {{(DATA_W-8){1'b0}}, byte_lane};
            EXT_LH:  result = {{(DATA_W-16){half_lane[15]}}, half_lane};
            EXT_LHU: result = {{(DATA_W-16){1'b0}}, half_lane};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/wb_stage_mux.sv
// Writeback source mux + result register; latency 1; holds while stalled, flush outranks stall.
// Optional load extension on source 1 enabled by defining WB_LOAD_EXT_EN.
module wb_stage_mux
    import wb_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int NUM_SRC = 4,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic [4:0]                rd_in,
    input  logic                      we_in,
    input  logic [2:0]                ext_mode,
    input  logic [1:0]                addr_lo,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      wb_valid,
    output logic [DATA_W-1:0]         wb_data,
    output logic [4:0]                wb_rd,
    output logic                      wb_we,
    output logic                      sel_err
);

    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] picked;
    logic              sel_ok;
    logic              accept;

`ifdef WB_LOAD_EXT_EN
    wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .data     (src_data[SRC_LOAD*DATA_W +: DATA_W]),
        .ext_mode (ext_mode),
        .addr_lo  (addr_lo),
        .result   (load_val)
    );
`else
    logic unused_ext;
    assign unused_ext = &{1'b0, ext_mode, addr_lo};
    assign load_val   = src_data[SRC_LOAD*DATA_W +: DATA_W];
`endif

    // Loop compare keeps out-of-range selects from indexing past the bus.
    always_comb begin
        picked = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (32'(sel) == i) begin
                picked = (i == SRC_LOAD) ? load_val : src_data[i*DATA_W +: DATA_W];
                sel_ok = 1'b1;
            end
        end
    end

    assign in_ready = !wb_valid || !stall;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_we    <= 1'b0;
            sel_err  <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
        end else if (accept) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_in;
            wb_we    <= we_in && (rd_in != 5'd0) && sel_ok;
            if (sel_ok) begin
                wb_data <= picked;
            end else begin
                sel_err <= 1'b1;
            end
        end else if (!stall) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_stage_mux.sv
// Directed bench for wb_stage_mux (NUM_SRC=3 so sel=3 is illegal); expectations
// track WB_LOAD_EXT_EN so the same vectors check both builds.
module tb_wb_stage_mux;

    localparam int DW = 32;
    localparam int NS = 3;

`ifdef WB_LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NS*DW-1:0] src_data;
    logic [1:0]    sel;
    logic [4:0]    rd_in;
    logic          we_in;
    logic [2:0]    ext_mode;
    logic [1:0]    addr_lo;
    logic          stall;
    logic          flush;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic [4:0]    wb_rd;
    logic          wb_we;
    logic          sel_err;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic acc_prev;

    always #5 Clk = ~Clk;

    wb_stage_mux #(.DATA_W(DW), .NUM_SRC(NS)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .src_data (src_data),
        .sel      (sel),
        .rd_in    (rd_in),
        .we_in    (we_in),
        .ext_mode (ext_mode),
        .addr_lo  (addr_lo),
        .stall    (stall),
        .flush    (flush),
        .wb_valid (wb_valid),
        .wb_data  (wb_data),
        .wb_rd    (wb_rd),
        .wb_we    (wb_we),
        .sel_err  (sel_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic put(input logic v, input logic [1:0] s, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                       input logic we, input logic [2:0] m, input logic [1:0] a,
                       input logic st, input logic fl);
        @(posedge Clk);
        #1;
        in_valid = v;
        sel      = s;
        src_data = {d2, d1, d0};
        rd_in    = rd;
        we_in    = we;
        ext_mode = m;
        addr_lo  = a;
        stall    = st;
        flush    = fl;
    endtask

    task automatic idle();
        put(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'b010, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic we);
        exp_t e;
        e.data = d;
        e.rd   = rd;
        e.we   = we;
        q.push_back(e);
    endtask

    // Monitor: any acceptance seen at a falling edge must appear at the next one.
    initial begin
        exp_t e;
        acc_prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (acc_prev) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got rd %0d data %h want none", wb_rd, wb_data);
                end else begin
                    e = q.pop_front();
                    chk("sb_valid", 32'(wb_valid), 32'd1);
                    chk("sb_data", wb_data, e.data);
                    chk("sb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("sb_we", 32'(wb_we), 32'(e.we));
                end
            end
            acc_prev = Rst_n && in_valid && in_ready && !flush;
        end
    end

    initial begin
        Rst_n = 1'b0;
        in_valid = 1'b0; sel = '0; src_data = '0; rd_in = '0; we_in = 1'b0;
        ext_mode = 3'b010; addr_lo = '0; stall = 1'b0; flush = 1'b0;
        @(negedge Clk);
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_rd", 32'(wb_rd), 32'd0);
        chk("rst_we", 32'(wb_we), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        Rst_n = 1'b1;

        // PC+4 source
        put(1, 2'd2, 32'h0, 32'h0, 32'h0000_1004, 5'd5, 1, 3'b010, 2'd0, 0, 0);
        push(32'h0000_1004, 5'd5, 1'b1);
        idle();
        idle();
        @(negedge Clk);
        chk("idle_clears_valid", 32'(wb_valid), 32'd0);

        // ALU source, no write
        put(1, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd7, 0, 3'b010, 2'd0, 0, 0);
        push(32'hDEAD_BEEF, 5'd7, 1'b0);
        // Load extension cases, back to back
        put(1, 2'd1, 32'h0, 32'h80FF_FFFF, 32'h0, 5'd3, 1, 3'b000, 2'd3, 0, 0);
        push(EXT ? 32'hFFFF_FF80 : 32'h80FF_FFFF, 5'd3, 1'b1);
        put(1, 2'd1, 32'h0, 32'h80FF_FFFF, 32'h0, 5'd3, 1, 3'b100, 2'd3, 0, 0);
        push(EXT ? 32'h0000_0080 : 32'h80FF_FFFF, 5'd3, 1'b1);
        put(1, 2'd1, 32'h0, 32'h8001_7F00, 32'h0, 5'd8, 1, 3'b101, 2'd2, 0, 0);
        push(EXT ? 32'h0000_8001 : 32'h8001_7F00, 5'd8, 1'b1);
        put(1, 2'd1, 32'h0, 32'h0000_8765, 32'h0, 5'd8, 1, 3'b001, 2'd0, 0, 0);
        push(EXT ? 32'hFFFF_8765 : 32'h0000_8765, 5'd8, 1'b1);
        put(1, 2'd1, 32'h0, 32'h8001_7F00, 32'h0, 5'd8, 1, 3'b111, 2'd3, 0, 0);
        push(32'h8001_7F00, 5'd8, 1'b1);
        // x0 destination never written
        put(1, 2'd0, 32'h0000_0055, 32'h0, 32'h0, 5'd0, 1, 3'b010, 2'd0, 0, 0);
        push(32'h0000_0055, 5'd0, 1'b0);
        idle();

        // Stall hold for three cycles with a new candidate waiting
        put(1, 2'd0, 32'hAAAA_0001, 32'h0, 32'h0, 5'd9, 1, 3'b010, 2'd0, 0, 0);
        push(32'hAAAA_0001, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            put(1, 2'd0, 32'hBBBB_0002, 32'h0, 32'h0, 5'd10, 1, 3'b010, 2'd0, 1, 0);
            @(negedge Clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_hold_data", wb_data, 32'hAAAA_0001);
            chk("stall_hold_rd", 32'(wb_rd), 32'd9);
            chk("stall_hold_valid", 32'(wb_valid), 32'd1);
        end
        put(1, 2'd0, 32'hBBBB_0002, 32'h0, 32'h0, 5'd10, 1, 3'b010, 2'd0, 0, 0);
        push(32'hBBBB_0002, 5'd10, 1'b1);
        idle();
        @(negedge Clk);
        chk("sel_err_clear", 32'(sel_err), 32'd0);

        // Illegal select keeps previous data
        put(1, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd4, 1, 3'b010, 2'd0, 0, 0);
        push(32'h0000_1234, 5'd4, 1'b1);
        put(1, 2'd3, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 5'd6, 1, 3'b010, 2'd0, 0, 0);
        push(32'h0000_1234, 5'd6, 1'b0);
        idle();
        @(negedge Clk);
        chk("sel_err_set", 32'(sel_err), 32'd1);
        put(1, 2'd0, 32'h0000_0077, 32'h0, 32'h0, 5'd11, 1, 3'b010, 2'd0, 0, 0);
        push(32'h0000_0077, 5'd11, 1'b1);
        // Flush together with stall
        put(1, 2'd0, 32'hCCCC_0003, 32'h0, 32'h0, 5'd12, 1, 3'b010, 2'd0, 1, 1);
        idle();
        @(negedge Clk);
        chk("flush_stall_valid", 32'(wb_valid), 32'd0);
        chk("flush_stall_we", 32'(wb_we), 32'd0);
        chk("flush_keep_data", wb_data, 32'h0000_0077);
        chk("flush_keep_rd", 32'(wb_rd), 32'd11);
        chk("sel_err_sticky", 32'(sel_err), 32'd1);

        // Flush drops a same-cycle acceptance
        put(1, 2'd2, 32'h0, 32'h0, 32'h0000_2468, 5'd13, 1, 3'b010, 2'd0, 0, 0);
        push(32'h0000_2468, 5'd13, 1'b1);
        put(1, 2'd0, 32'hDDDD_0004, 32'h0, 32'h0, 5'd14, 1, 3'b010, 2'd0, 0, 1);
        idle();
        @(negedge Clk);
        chk("flush_drop_valid", 32'(wb_valid), 32'd0);
        chk("flush_drop_rd", 32'(wb_rd), 32'd13);
        chk("flush_drop_data", wb_data, 32'h0000_2468);

        // Reset mid-stall
        put(1, 2'd0, 32'hEEEE_0005, 32'h0, 32'h0, 5'd15, 1, 3'b010, 2'd0, 0, 0);
        push(32'hEEEE_0005, 5'd15, 1'b1);
        put(0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 3'b010, 2'd0, 1, 0);
        @(negedge Clk);
        chk("pre_rst_valid", 32'(wb_valid), 32'd1);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_data", wb_data, 32'd0);
        chk("mid_rst_rd", 32'(wb_rd), 32'd0);
        chk("mid_rst_we", 32'(wb_we), 32'd0);
        chk("mid_rst_sel_err", 32'(sel_err), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        put(1, 2'd2, 32'h0, 32'h0, 32'h0000_2000, 5'd1, 1, 3'b010, 2'd0, 1, 0);
        push(32'h0000_2000, 5'd1, 1'b1);
        idle();
        idle();
        idle();
        @(negedge Clk);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
